// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe: registered ALU with valid/ready on both sides, an iterative
// shift-add multiplier and a {C,N,V,Z} status word.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          synchronous abort of in-flight / held results
//   in_valid/in_ready, a, b, c_in, op   operation input handshake
//   out_valid/out_ready, result, status output handshake, status = {C,N,V,Z}
//   busy           high while a multiply is iterating
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holds its payload stable while
// valid=1 and ready=0. result/status only change on a transfer, a completed
// multiply or reset; flush leaves them untouched.
//
// Internal FSM state is the signal "state" (IDLE / BUSY / HOLD) for checkers.
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_XOR  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110;
    localparam logic [3:0] OP_ZERO = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_ASR  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic             rdy_en;     // keeps in_ready low until the first edge after reset
    logic [WIDTH-1:0] mcand;      // multiplicand, fixed during BUSY
    logic [WIDTH-1:0] prod_hi;    // upper product half (running partial sum)
    logic [WIDTH-1:0] prod_lo;    // multiplier bits shift out, product low bits shift in
    logic [SH_W-1:0]  cnt;

    logic             accept;
    logic             is_mul;

    assign in_ready  = rdy_en & ((state == IDLE) | ((state == HOLD) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == HOLD);
    assign busy      = (state == BUSY);
    assign is_mul    = MUL_EN && (op == OP_MUL);

    // Single-cycle datapath
    logic [SH_W-1:0]  sh;
    logic [WIDTH:0]   add_full, sub_full, shl_full, shr_full, asr_full;
    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [3:0]       alu_status;

    always_comb begin
        sh       = b[SH_W-1:0];
        b_inv    = ~b;
        add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
        sub_full = {1'b0, a} + {1'b0, b_inv} + {{WIDTH{1'b0}}, 1'b1};
        // One extra bit below/above the operand catches the last bit shifted
        // out; it is naturally 0 for a zero shift amount.
        shl_full = {1'b0, a} << sh;
        shr_full = {a, 1'b0} >> sh;
        asr_full = $signed({a, 1'b0}) >>> sh;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            OP_XOR:  alu_res = a ^ b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_ADD: begin
                {alu_c, alu_res} = add_full;
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                {alu_c, alu_res} = sub_full;
                alu_v = (a[WIDTH-1] == b_inv[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: begin
                alu_res = shl_full[WIDTH-1:0];
                alu_c   = shl_full[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_full[WIDTH:1];
                alu_c   = shr_full[0];
            end
            OP_ASR: begin
                alu_res = asr_full[WIDTH:1];
                alu_c   = asr_full[0];
            end
            OP_ZERO: alu_res = '0;
            // Illegal ops (and MUL when reaching here) give 0 with C=V=0,
            // so the status below becomes 4'b0001 automatically.
            default: alu_res = '0;
        endcase
        alu_status = {alu_c, alu_res[WIDTH-1], alu_v, (alu_res == '0)};
    end

    // One shift-add step: add multiplicand to upper half if the current
    // multiplier LSB is set, then shift the whole product right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
    logic [3:0]       mul_status;

    always_comb begin
        mul_sum    = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], prod_lo[WIDTH-1:1]};
        mul_status = {(mul_hi_nxt != '0), mul_lo_nxt[WIDTH-1], 1'b0, (mul_lo_nxt == '0)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdy_en  <= 1'b0;
            result  <= '0;
            status  <= '0;
            mcand   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
            cnt     <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    BUSY: begin
                        prod_hi <= mul_hi_nxt;
                        prod_lo <= mul_lo_nxt;
                        cnt     <= cnt + SH_W'(1);
                        if (cnt == SH_W'(WIDTH - 1)) begin
                            result <= mul_lo_nxt;
                            status <= mul_status;
                            state  <= HOLD;
                        end
                    end
                    default: begin
                        // IDLE, or HOLD where in_ready already implies out_ready
                        if (accept) begin
                            if (is_mul) begin
                                mcand   <= a;
                                prod_hi <= '0;
                                prod_lo <= b;
                                cnt     <= '0;
                                state   <= BUSY;
                            end else begin
                                result <= alu_res;
                                status <= alu_status;
                                state  <= HOLD;
                            end
                        end else if (state == HOLD && out_ready) begin
                            state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's combinational 32-bit ALU.
- Accepts one operation per valid/ready handshake and returns the result plus a correct {C,N,V,Z} status word through an output valid/ready handshake.
- Adds arithmetic shift and an iterative shift-add multiply, which the combinational ALU lacks.
- Sits between the operand-fetch stage and writeback.

Parameters:
- WIDTH, 32: operand/result width; must be >= 4 and a power of 2.
- MUL_EN, 1: 1 = MUL opcode implemented; 0 = MUL treated as an illegal opcode.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; drops in-flight and held results.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in, used by ADD only.
- op  input  4  operation select.
- out_valid  output  1  result and status are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- status  output  4  {C,N,V,Z}.
- busy  output  1  high while a multiply is iterating.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n=0: state IDLE; out_valid=0, result=0, status=0, busy=0, in_ready=0.
  - in_ready becomes 1 on the first clk edge after rst_n deasserts.
- States:
  - IDLE: no result held.
  - BUSY: multiply iterating.
  - HOLD: result held, out_valid=1.
- Handshakes:
  - Input accept = in_valid & in_ready at a clk edge.
  - in_ready = (IDLE) | (HOLD & out_ready).
  - Output transfer = out_valid & out_ready.
  - result and status must stay stable while out_valid=1 and out_ready=0.
- Latency:
  - Non-MUL ops: result registered at the accept edge; HOLD with out_valid=1 from the next cycle (1 cycle). Back-to-back throughput is 1 op per cycle when out_ready=1.
  - MUL: the accept edge loads operands, then BUSY for WIDTH edges (one multiplier bit per edge, LSB first). Result registered on the WIDTH-th edge, then HOLD.
  - busy=1 throughout BUSY; in_ready=0 in BUSY.
- Opcodes (any unlisted op, or MUL with MUL_EN=0, is illegal: result 0, status 4'b0001, latency 1):
  - 0000 XOR; 0001 AND; 0010 OR; 0011 NOR.
  - 0100 ADD = a+b+c_in.
  - 1100 SUB = a+~b+1; c_in ignored.
  - 0101 SHL: shift left logical.
  - 0110 SHR: shift right logical.
  - 1101 ASR: shift right arithmetic.
  - Shift amount = b[log2(WIDTH)-1:0]; upper bits of b are ignored.
  - 0111 ZERO: result 0.
  - 1000 MUL: low WIDTH bits of unsigned a*b.
- Status flags, all WIDTH-bit exact:
  - N = result[WIDTH-1].
  - Z = 1 iff all bits of result are 0, including the MSB.
  - ADD/SUB: C = carry-out of bit WIDTH-1 (for SUB, C=1 means no borrow, i.e. a>=b unsigned). V = signed overflow (operand signs equal and result sign differs, using ~b for SUB).
  - Shifts: C = last bit shifted out; C=0 when amount=0. V=0.
  - Logic ops and ZERO: C=0, V=0.
  - MUL: C=1 iff the upper WIDTH product bits are nonzero. V=0.
- flush (sampled each edge):
  - Forces IDLE, out_valid=0, busy=0; result and status keep their old values.
  - Any input accepted that cycle is discarded.
  - flush has priority over accept and over completion.
- Asserting reset mid-multiply returns to IDLE immediately; no result is ever produced.
- Output completion and a new accept may coincide in HOLD with out_ready=1. The new result replaces the old in the same edge, and out_valid stays 1.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, status=0. The first accept happens one edge after release.
- ADD overflow: a=32'h7FFFFFFF, b=1, c_in=0, op=0100 -> next cycle result=32'h80000000, status=4'b0110 (C0 N1 V1 Z0).
- SUB wrap: a=0, b=1, op=1100 -> result=32'hFFFFFFFF, status=4'b0100. Then a=5, b=5 -> result 0, status=4'b1001.
- Shifts: a=32'h80000001, b=1 gives: SHL -> 32'h00000002, C=1. ASR -> 32'hC0000000, C=1, N=1. SHR with b=32 (amount 0) -> unchanged, C=0.
- MUL: a=32'h00010000, b=32'h00010000 -> busy for 32 cycles, in_ready=0, then result=0, status=4'b1001. With a=7, b=6 -> result=42, status=0.
- Backpressure/flush: hold out_ready=0 with a result held -> result stable, in_ready=0. Assert flush at MUL iteration 10 -> out_valid never rises, and IDLE with in_ready=1 follows the flush edge.
